// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates the decoded branch condition, computes the
// redirect PC and holds the result in a valid/ready output register with statistics.
module branch_resolve #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             beq,
  input  logic             bne,
  input  logic             blt,
  input  logic             bge,
  input  logic             bltu,
  input  logic             bgeu,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_branch,
  output logic             illegal,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  logic [5:0]       strb;
  logic [2:0]       strb_cnt;
  logic             one_hot;
  logic             multi;
  logic             eq, lts, ltu;
  logic             cond;
  logic             taken_d;
  logic             mp_d;
  logic [XLEN-1:0]  redirect_d;
  logic             accept;

  logic             out_valid_q;
  logic             is_branch_q;
  logic             illegal_q;
  logic             taken_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;

  assign strb = {beq, bne, blt, bge, bltu, bgeu};

  always_comb begin
    strb_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      strb_cnt = strb_cnt + {2'b00, strb[i]};
    end
  end

  assign one_hot = (strb_cnt == 3'd1);
  assign multi   = (strb_cnt > 3'd1);

  assign eq  = (rs1_val == rs2_val);
  assign lts = ($signed(rs1_val) < $signed(rs2_val));
  assign ltu = (rs1_val < rs2_val);

  assign cond = (beq & eq) | (bne & ~eq) | (blt & lts) | (bge & ~lts) |
                (bltu & ltu) | (bgeu & ~ltu);

  // Illegal or non-branch instructions never take and never mispredict.
  assign taken_d    = one_hot & cond;
  assign mp_d       = one_hot & (taken_d != pred_taken);
  assign redirect_d = taken_d ? (pc + imm) : (pc + XLEN'(4));

  assign in_ready = (!out_valid_q || out_ready) && !kill && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      is_branch_q  <= 1'b0;
      illegal_q    <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      if (kill) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q  <= 1'b1;
        is_branch_q  <= one_hot;
        illegal_q    <= multi;
        taken_q      <= taken_d;
        mispredict_q <= mp_d;
        redirect_q   <= redirect_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Saturating statistics; a later kill never rolls them back.
      if (accept && one_hot && (br_cnt_q != {CNT_W{1'b1}})) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      end
      if (accept && mp_d && (mp_cnt_q != {CNT_W{1'b1}})) begin
        mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign is_branch   = out_valid_q & is_branch_q;
  assign illegal     = out_valid_q & illegal_q;
  assign taken       = out_valid_q & taken_q;
  assign mispredict  = out_valid_q & mispredict_q;
  assign redirect_pc = redirect_q;
  assign br_count    = br_cnt_q;
  assign mp_count    = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed vectors push hand-computed results,
// a negedge monitor compares whatever the DUT presents against the queue front.
module tb_branch_resolve;

  localparam logic [5:0] SBEQ  = 6'b100000;
  localparam logic [5:0] SBNE  = 6'b010000;
  localparam logic [5:0] SBLT  = 6'b001000;
  localparam logic [5:0] SBGE  = 6'b000100;
  localparam logic [5:0] SBLTU = 6'b000010;
  localparam logic [5:0] SBGEU = 6'b000001;
  localparam logic [5:0] SNONE = 6'b000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        beq = 1'b0, bne = 1'b0, blt = 1'b0, bge = 1'b0, bltu = 1'b0, bgeu = 1'b0;
  logic [31:0] rs1_val = '0, rs2_val = '0, pc = '0, imm = '0;
  logic        pred_taken = 1'b0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        is_branch, illegal, taken, mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_count, mp_count;

  int checks = 0;
  int errors = 0;
  logic [35:0] q[$];

  branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .beq(beq), .bne(bne), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .is_branch(is_branch),
    .illegal(illegal), .taken(taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] mk(input logic br, input logic ill, input logic tk,
                                     input logic mp, input logic [31:0] rpc);
    return {br, ill, tk, mp, rpc};
  endfunction

  task automatic drive(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pt);
    {beq, bne, blt, bge, bltu, bgeu} = s;
    rs1_val = a; rs2_val = b; pc = p; imm = i; pred_taken = pt;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i, input logic pt,
                      input logic [35:0] e, output int waits);
    bit done = 0;
    waits = 0;
    drive(s, a, b, p, i, pt);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input logic [15:0] br, input logic [15:0] mp);
    @(negedge clk);
    chk("br_count", 64'(br_count), 64'(br));
    chk("mp_count", 64'(mp_count), 64'(mp));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented result; retire it on consume, kill or reset.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        chk("result", 64'({is_branch, illegal, taken, mispredict, redirect_pc}), 64'(q[0]));
        if (out_ready || kill || reset) void'(q.pop_front());
      end
    end else begin
      chk("idle_flags", 64'({is_branch, illegal, taken, mispredict}), 64'd0);
    end
  end

  initial begin
    int w;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_redirect", 64'(redirect_pc), 64'd0);
    chk("rst_br", 64'(br_count), 64'd0);
    chk("rst_mp", 64'(mp_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send(SBEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, mk(1, 0, 1, 1, 32'h120), w);
    chk("first_latency", 64'(w), 64'd0);
    drain();
    chk_cnt(16'd1, 16'd1);

    send(SBLT,  32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 1'b1, mk(1, 0, 1, 0, 32'h210), w);
    send(SBLTU, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 1'b1, mk(1, 0, 0, 1, 32'h204), w);
    send(SBGE,  32'd7, 32'd7, 32'h300, 32'hFFFFFFF0, 1'b0, mk(1, 0, 1, 1, 32'h2F0), w);
    send(SBGEU, 32'd0, 32'd1, 32'h400, 32'h40, 1'b0, mk(1, 0, 0, 0, 32'h404), w);
    send(SBNE,  32'd1, 32'd2, 32'hFFFFFFFC, 32'd8, 1'b1, mk(1, 0, 1, 0, 32'h4), w);
    send(SBEQ,  32'd1, 32'd2, 32'hFFFFFFFC, 32'd8, 1'b0, mk(1, 0, 0, 0, 32'h0), w);
    drain();
    chk_cnt(16'd7, 16'd3);

    send(SBEQ | SBNE, 32'd3, 32'd3, 32'h500, 32'h10, 1'b1, mk(0, 1, 0, 0, 32'h504), w);
    send(SNONE, 32'd3, 32'd3, 32'h600, 32'h10, 1'b1, mk(0, 0, 0, 0, 32'h604), w);
    drain();
    chk_cnt(16'd7, 16'd3);

    // Stall: result held while the next instruction waits.
    out_ready = 1'b0;
    send(SBEQ, 32'd2, 32'd2, 32'h700, 32'h4, 1'b1, mk(1, 0, 1, 0, 32'h704), w);
    drive(SBLT, 32'd1, 32'd2, 32'h710, 32'h20, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(SBLT,  32'd1, 32'd2, 32'h710, 32'h20, 1'b0, mk(1, 0, 1, 1, 32'h730), w);
    chk("b2b_wait0", 64'(w), 64'd0);
    send(SBLTU, 32'd2, 32'd1, 32'h720, 32'h8, 1'b0, mk(1, 0, 0, 0, 32'h724), w);
    chk("b2b_wait1", 64'(w), 64'd0);
    send(SBGE,  32'd1, 32'd2, 32'h730, 32'h8, 1'b1, mk(1, 0, 0, 1, 32'h734), w);
    chk("b2b_wait2", 64'(w), 64'd0);
    drain();
    chk_cnt(16'd11, 16'd5);

    // Kill during a stall drops the held result but keeps the statistics.
    out_ready = 1'b0;
    send(SBGEU, 32'd5, 32'd3, 32'h800, 32'h10, 1'b1, mk(1, 0, 1, 0, 32'h810), w);
    kill = 1'b1;
    @(negedge clk);
    chk("kill_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk_cnt(16'd12, 16'd5);

    // Reset during a stall.
    send(SBEQ, 32'd0, 32'd0, 32'h900, 32'h10, 1'b1, mk(1, 0, 1, 0, 32'h910), w);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_redirect", 64'(redirect_pc), 64'd0);
    chk("rst2_br", 64'(br_count), 64'd0);
    chk("rst2_mp", 64'(mp_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(SBGEU, 32'd3, 32'd3, 32'hA00, 32'h8, 1'b1, mk(1, 0, 1, 0, 32'hA08), w);
    chk("post_rst_wait", 64'(w), 64'd0);

    // Saturation of br_count.
    for (int n = 0; n < 65534; n++) begin
      send(SBNE, 32'd1, 32'd2, 32'h0, 32'h8, 1'b1, mk(1, 0, 1, 0, 32'h8), w);
    end
    drain();
    chk_cnt(16'hFFFF, 16'd0);
    send(SBNE, 32'd1, 32'd2, 32'h0, 32'h8, 1'b1, mk(1, 0, 1, 0, 32'h8), w);
    drain();
    chk_cnt(16'hFFFF, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
